fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the main control decoder.
- Holds the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents the held instruction and its opcode field to decode, then computes the next PC (sequential, beq-taken, or j) when the core commits the instruction.
- Adds a retired-instruction counter for debug and bench checking.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  byte address of the fetch; equals pc.
- imem_ack  in  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  in  32  instruction word from memory.
- instr  out  32  held instruction.
- opcode  out  6  instr[31:26]; feeds the control decoder.
- instr_valid  out  1  instr/opcode/pc are valid for decode/execute.
- pc  out  32  address of the held instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- advance  in  1  core commits the held instruction this cycle.
- branch  in  1  Branch output of the control decoder.
- zero  in  1  ALU zero flag.
- retired_count  out  CNT_W  number of committed instructions.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - pc = RESET_PC, instr = 0, instr_valid = 0, imem_req = 0, retired_count = 0.
  - A fetch in flight is abandoned; imem_req drops immediately.
- States:
  - IDLE: imem_req = 0. Next cycle goes unconditionally to FETCH.
  - FETCH: imem_req = 1, imem_addr = pc, both held stable until ack.
    - On imem_ack: latch instr <= imem_rdata, go to VALID.
    - imem_ack in the same cycle req first rises is legal (zero-wait memory).
  - VALID: instr_valid = 1, imem_req = 0.
    - On advance: update pc, increment retired_count, go to FETCH.
    - Without advance: hold instr and pc indefinitely (stall).
- imem_req and instr_valid are decoded from the state register only, with no combinational path from inputs.
- Latency:
  - ack in cycle N gives instr_valid = 1 in N+1.
  - advance in cycle M gives the new pc and imem_req = 1 in M+1.
  - Minimum 2 cycles per instruction.
- Next-PC selection, evaluated only in VALID with advance = 1, in priority order:
  - opcode == 6'b000010 (j): pc <= {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch & zero: pc <= pc_plus4 + (sign_extend(instr[15:0]) << 2), 32-bit, carry out discarded.
  - Otherwise: pc <= pc_plus4.
- branch and zero are ignored when advance = 0 or state != VALID.
- imem_ack outside FETCH is ignored. advance outside VALID is ignored and retired_count does not change.
- PC arithmetic wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- retired_count wraps at 2^CNT_W to 0.
- Negative branch offsets are legal: offset 16'hFFFF gives pc_plus4 - 4, i.e. a self-loop.
- The PC always stays word-aligned; imem_addr[1:0] is always 0.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: RESET_PC = 0, zero-wait memory returning 0x8C080004 (lw) at 0, then 0x00000000.
  - Required response: imem_req low during reset and the first cycle after; req at addr 0; instr_valid next cycle with opcode 6'b100011.
  - Then advance: next req at addr 4, pc_plus4 = 8 afterwards, retired_count = 1.
- Wait-state memory:
  - Stimulus: imem_ack delayed 3 cycles after req.
  - Required response: imem_addr and imem_req stable for all 4 cycles; instr_valid exactly one cycle after ack; rdata presented while ack = 0 is not latched.
- Taken/untaken beq:
  - Stimulus: pc = 0x40, instr = 0x1109FFFE (offset -2).
  - With branch = 1, zero = 1, advance: next pc = 0x3C.
  - With zero = 0: next pc = 0x44.
- Jump:
  - Stimulus: pc = 0x1000_0010, instr = 0x08000100.
  - Required response: next pc = 0x1000_0400; branch = 1, zero = 1 in the same cycle have no effect.
- Stall and ignored inputs:
  - Stimulus: hold advance = 0 for 10 cycles in VALID while toggling imem_ack, branch, and zero.
  - Required response: instr, pc, and retired_count unchanged; imem_req stays 0.
- Reset mid-fetch and wrap:
  - Stimulus: assert rst_n low during FETCH with ack pending.
  - Required response: imem_req drops in the same cycle; pc = RESET_PC.
  - Stimulus: RESET_PC = 32'hFFFF_FFFC, then advance.
  - Required response: next fetch address = 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, fetches instructions over req/ack and selects the next PC on commit
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      instr,
   output logic [5:0]       opcode,
   output logic             instr_valid,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   input  logic             advance,
   input  logic             branch,
   input  logic             zero,
   output logic [CNT_W-1:0] retired_count
);
   typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
   state_t state;
   logic [31:0] branchTarget, jumpTarget, nextPc;
   // handshake outputs come straight from the state register, never from inputs
   assign imem_req    = state == FETCH;
   assign instr_valid = state == VALID;
   assign imem_addr   = pc;
   assign opcode      = instr[31:26];
   assign pc_plus4    = pc + 32'd4;
   always_comb begin
      branchTarget = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
      jumpTarget   = {pc_plus4[31:28], instr[25:0], 2'b00};
      nextPc       = (opcode == 6'b000010) ? jumpTarget : (branch && zero) ? branchTarget : pc_plus4;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         pc            <= RESET_PC;
         instr         <= '0;
         retired_count <= '0;
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH: if (imem_ack) begin
               instr <= imem_rdata;
               state <= VALID;
            end
            VALID: if (advance) begin
               pc            <= nextPc;
               retired_count <= retired_count + CNT_W'(1);
               state         <= FETCH;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: three fetch units with different reset PCs checked against a behavioural model
module tb_fetch_unit;
   localparam logic [31:0] RST [3] = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h1000_000C};
   localparam int IDLE = 0, FETCH = 1, VALID = 2;
   logic clk = 1'b0, rst_n = 1'b0, imem_ack = 1'b0, advance = 1'b0, branch = 1'b0, zero = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic reqO [3], validO [3];
   logic [31:0] addrO [3], instrO [3], pcO [3], p4O [3], cntO [3];
   logic [5:0] opO [3];
   int errors = 0, checks = 0, mStage = IDLE;
   logic [31:0] mPc [3], mInstr, mCount;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : gDut
      fetch_unit #(.RESET_PC(RST[g]), .CNT_W(32)) dut (
         .clk(clk), .rst_n(rst_n), .imem_req(reqO[g]), .imem_addr(addrO[g]),
         .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instrO[g]), .opcode(opO[g]),
         .instr_valid(validO[g]), .pc(pcO[g]), .pc_plus4(p4O[g]), .advance(advance),
         .branch(branch), .zero(zero), .retired_count(cntO[g]));
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [31:0] nextPc(input logic [31:0] p, input logic [31:0] ins, input logic br, input logic z);
      logic [31:0] p4 = p + 32'd4;
      logic [31:0] off = {{16{ins[15]}}, ins[15:0]};
      if (ins[31:26] == 6'b000010) return {p4[31:28], ins[25:0], 2'b00};
      if (br && z) return p4 + off * 32'd4;
      return p4;
   endfunction
   function automatic logic [31:0] randInstr();
      case ($urandom_range(0, 3))
         0: return {6'b000010, 26'($urandom)};
         1: return {6'b000100, 26'($urandom)};
         default: return 32'($urandom);
      endcase
   endfunction
   task automatic resetModel();
      mStage = IDLE;
      mCount = '0;
      mInstr = '0;
      for (int i = 0; i < 3; i++) mPc[i] = RST[i];
   endtask
   task automatic checkAll();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("req%0d", i), 32'(reqO[i]), 32'(mStage == FETCH));
         check($sformatf("valid%0d", i), 32'(validO[i]), 32'(mStage == VALID));
         check($sformatf("addr%0d", i), addrO[i], mPc[i]);
         check($sformatf("pc%0d", i), pcO[i], mPc[i]);
         check($sformatf("pcPlus4_%0d", i), p4O[i], mPc[i] + 32'd4);
         check($sformatf("instr%0d", i), instrO[i], mInstr);
         check($sformatf("opcode%0d", i), 32'(opO[i]), 32'(mInstr[31:26]));
         check($sformatf("retired%0d", i), cntO[i], mCount);
      end
   endtask
   task automatic cyc(input logic ack, input logic [31:0] rd, input logic adv, input logic br, input logic z);
      imem_ack = ack;
      imem_rdata = rd;
      advance = adv;
      branch = br;
      zero = z;
      if (mStage == IDLE) mStage = FETCH;
      else if (mStage == FETCH && ack) begin
         mInstr = rd;
         mStage = VALID;
      end else if (mStage == VALID && adv) begin
         for (int i = 0; i < 3; i++) mPc[i] = nextPc(mPc[i], mInstr, br, z);
         mCount = mCount + 32'd1;
         mStage = FETCH;
      end
      @(negedge clk);
      checkAll();
   endtask
   initial begin
      resetModel();
      repeat (2) @(negedge clk);
      checkAll();
      rst_n = 1'b1;
      checkAll();
      cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
      cyc(1'b1, 32'h8C08_0004, 1'b0, 1'b0, 1'b0);
      check("lwOpcode", 32'(opO[0]), 32'h23);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("seqAddr", addrO[0], 32'h4);
      check("seqPlus4", p4O[0], 32'h8);
      check("wrapAddr", addrO[1], 32'h0);
      repeat (3) cyc(1'b0, 32'($urandom), 1'b1, 1'b1, 1'b1);
      cyc(1'b1, 32'h0800_0100, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      check("jumpPc", pcO[2], 32'h1000_0400);
      cyc(1'b1, 32'h0800_0010, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'h1109_FFFE, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      check("beqTaken", pcO[0], 32'h3C);
      cyc(1'b1, 32'h0800_0010, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'h1109_FFFE, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("beqUntaken", pcO[0], 32'h44);
      cyc(1'b1, 32'h1109_FFFE, 1'b0, 1'b0, 1'b0);
      repeat (10) cyc(1'($urandom), 32'($urandom), 1'b0, 1'($urandom), 1'($urandom));
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      #2 imem_ack = 1'b1;
      rst_n = 1'b0;
      #1 resetModel();
      checkAll();
      @(negedge clk);
      rst_n = 1'b1;
      imem_ack = 1'b0;
      checkAll();
      repeat (3000) cyc(1'($urandom_range(0, 2) == 0), randInstr(), 1'($urandom), 1'($urandom), 1'($urandom));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
